// File: rtl/cache_data_array_arbiter.sv
// Two-port arbiter in front of a single-port cache data SRAM.
// Define CACHE_ARB_RR_EN for round-robin arbitration; default is fixed A-priority.
module cache_data_array_arbiter #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [NUM_WMASKS-1:0] a_wmask,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ready,
   output logic                  a_rvalid,
   input  logic                  a_rready,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [NUM_WMASKS-1:0] b_wmask,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ready,
   output logic                  b_rvalid,
   input  logic                  b_rready,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   typedef enum logic [1:0] {IDLE, RESP_A, RESP_B} state_t;

   state_t state, state_nxt;
   logic   can_gnt;
   logic   gnt_a;
   logic   gnt_b;
   logic   sel_we;
   logic   hs_a;
   logic   hs_b;

   assign hs_a = (state == RESP_A) && a_rready;
   assign hs_b = (state == RESP_B) && b_rready;

   // A pending response blocks new grants until its handshake cycle
   assign can_gnt = !rst && ((state == IDLE) || hs_a || hs_b);

`ifdef CACHE_ARB_RR_EN
   logic last_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_b <= 1'b1;
      end else if (gnt_a || gnt_b) begin
         last_b <= gnt_b;
      end
   end

   assign gnt_a = can_gnt && a_req && (!b_req || last_b);
   assign gnt_b = can_gnt && b_req && (!a_req || !last_b);
`else
   assign gnt_a = can_gnt && a_req;
   assign gnt_b = can_gnt && b_req && !a_req;
`endif

   assign a_ready  = gnt_a;
   assign b_ready  = gnt_b;
   assign a_rvalid = (state == RESP_A);
   assign b_rvalid = (state == RESP_B);
   assign a_rdata  = sram_dout;
   assign b_rdata  = sram_dout;

   always_comb begin
      sram_addr  = a_addr;
      sram_wmask = a_wmask;
      sram_din   = a_wdata;
      sel_we     = a_we;
      unique case (1'b1)
         gnt_b: begin
            sram_addr  = b_addr;
            sram_wmask = b_wmask;
            sram_din   = b_wdata;
            sel_we     = b_we;
         end
         default: ;
      endcase
      sram_csb = !(gnt_a || gnt_b);
      sram_web = !(!sram_csb && sel_we);
   end

   always_comb begin
      state_nxt = state;
      if (hs_a || hs_b) begin
         state_nxt = IDLE;
      end
      if (gnt_a && !a_we) begin
         state_nxt = RESP_A;
      end
      if (gnt_b && !b_we) begin
         state_nxt = RESP_B;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

endmodule

// File: tb/tb_cache_data_array_arbiter.sv
// Scoreboard bench for cache_data_array_arbiter with a behavioural SRAM.
// Build with CACHE_ARB_RR_EN defined to check round-robin arbitration.
module tb_cache_data_array_arbiter;

   localparam int DW = 256;
   localparam int AW = 4;
   localparam int NM = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_we, a_ready, a_rvalid, a_rready;
   logic [AW-1:0] a_addr;
   logic [NM-1:0] a_wmask;
   logic [DW-1:0] a_wdata, a_rdata;
   logic          b_req, b_we, b_ready, b_rvalid, b_rready;
   logic [AW-1:0] b_addr;
   logic [NM-1:0] b_wmask;
   logic [DW-1:0] b_wdata, b_rdata;
   logic          sram_csb, sram_web;
   logic [AW-1:0] sram_addr;
   logic [NM-1:0] sram_wmask;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout;

   logic [DW-1:0] sram  [16];
   logic [DW-1:0] model [16];
   logic [DW-1:0] qa [$];
   logic [DW-1:0] qb [$];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cache_data_array_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)
   ) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
      .a_wmask(a_wmask), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_rvalid(a_rvalid),
      .a_rready(a_rready), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
      .b_wmask(b_wmask), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_rvalid(b_rvalid),
      .b_rready(b_rready), .b_rdata(b_rdata),
      .sram_csb(sram_csb), .sram_web(sram_web),
      .sram_addr(sram_addr), .sram_wmask(sram_wmask),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Single-port SRAM: read data appears after the edge, holds while idle
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int j = 0; j < NM; j++)
               if (sram_wmask[j])
                  sram[sram_addr][8*j +: 8] <= sram_din[8*j +: 8];
         end else begin
            sram_dout <= sram[sram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] d,
                                           input logic [NM-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int j = 0; j < NM; j++)
         if (m[j]) r[8*j +: 8] = d[8*j +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("rvalid_onehot", DW'(a_rvalid & b_rvalid), '0);
         chk("one_grant", DW'(a_ready & b_ready), '0);
         if (a_rvalid && a_rready) begin
            if (qa.size() == 0) chk("a_unexpected", 1, 0);
            else chk("a_rdata", a_rdata, qa.pop_front());
         end
         if (b_rvalid && b_rready) begin
            if (qb.size() == 0) chk("b_unexpected", 1, 0);
            else chk("b_rdata", b_rdata, qb.pop_front());
         end
         if (a_req && a_ready) begin
            if (a_we) model[a_addr] = merge(model[a_addr], a_wdata, a_wmask);
            else qa.push_back(model[a_addr]);
         end
         if (b_req && b_ready) begin
            if (b_we) model[b_addr] = merge(model[b_addr], b_wdata, b_wmask);
            else qb.push_back(model[b_addr]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input bit pb, input bit we, input int addr,
                       input logic [NM-1:0] m, input logic [DW-1:0] d);
      bit ok;
      ok = 1'b0;
      if (!pb) begin
         a_req = 1'b1; a_we = we; a_addr = addr[AW-1:0];
         a_wmask = m; a_wdata = d;
      end else begin
         b_req = 1'b1; b_we = we; b_addr = addr[AW-1:0];
         b_wmask = m; b_wdata = d;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pb ? b_ready : a_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("xfer_timeout", 0, 1);
      tick();
      if (!pb) a_req = 1'b0;
      else b_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (qa.size() + qb.size()) != 0; i++)
         @(posedge clk);
      #1;
      chk("drain", DW'(qa.size() + qb.size()), '0);
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      qa.delete();
      qb.delete();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] held;
      logic [3:0]    gseq;
      logic [3:0]    gexp;
      logic [31:0]   w;

      for (int i = 0; i < 16; i++) begin
         sram[i] = '0;
         model[i] = '0;
      end
      sram_dout = '0;
      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wmask = '0; a_wdata = '0;
      b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wmask = '0; b_wdata = '0;
      a_rready = 1'b1; b_rready = 1'b1;
      #12;
      chk("rst_a_ready", DW'(a_ready), '0);
      chk("rst_b_ready", DW'(b_ready), '0);
      chk("rst_a_rvalid", DW'(a_rvalid), '0);
      chk("rst_b_rvalid", DW'(b_rvalid), '0);
      chk("rst_csb", DW'(sram_csb), 1);
      chk("rst_web", DW'(sram_web), 1);
      tick();
      rst = 1'b0; a_req = 1'b0; b_req = 1'b0;

      // write then immediate read-back on port A
      xfer(0, 1, 3, '1, {32{8'hAA}});
      xfer(0, 0, 3, '0, '0);
      chk("t1_rvalid", DW'(a_rvalid), 1);
      @(negedge clk);
      chk("t1_rdata", a_rdata, {32{8'hAA}});
      drain();

      // partial byte write on port B, then zero-mask write
      xfer(1, 1, 5, '1, '0);
      xfer(1, 1, 5, 32'h1, {32{8'hFF}});
      xfer(1, 0, 5, '0, '0);
      @(negedge clk);
      chk("t2_rdata", b_rdata, DW'(8'hFF));
      drain();
      xfer(1, 1, 5, '0, '1);
      xfer(1, 0, 5, '0, '0);
      @(negedge clk);
      chk("t2_zmask", b_rdata, DW'(8'hFF));
      drain();

      // stalled A response blocks B
      xfer(0, 1, 1, '1, {8{32'h0BAD_CAFE}});
      a_rready = 1'b0;
      xfer(0, 0, 1, '0, '0);
      b_req = 1'b1; b_we = 1'b0; b_addr = 4'd3;
      @(negedge clk);
      held = a_rdata;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         chk("stall_b_ready", DW'(b_ready), '0);
         chk("stall_csb", DW'(sram_csb), 1);
         chk("stall_rvalid", DW'(a_rvalid), 1);
         chk("stall_rdata", a_rdata, held);
      end
      tick();
      a_rready = 1'b1;
      @(negedge clk);
      chk("stall_hs_b_gnt", DW'(b_ready), 1);
      tick();
      b_req = 1'b0;
      drain();

      // contention, both ports writing for 4 cycles
      do_reset();
      a_req = 1'b1; a_we = 1'b1; a_addr = 4'd8; a_wmask = '1;
      a_wdata = {32{8'h5A}};
      b_req = 1'b1; b_we = 1'b1; b_addr = 4'd9; b_wmask = '1;
      b_wdata = {32{8'hC3}};
      gseq = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("arb_any_gnt", DW'(a_ready | b_ready), 1);
         gseq[i] = b_ready;
         tick();
      end
      a_req = 1'b0; b_req = 1'b0;
`ifdef CACHE_ARB_RR_EN
      gexp = 4'b1010;
`else
      gexp = 4'b0000;
`endif
      chk("arb_seq", DW'(gseq), DW'(gexp));
      xfer(0, 0, 8, '0, '0);
      xfer(1, 0, 9, '0, '0);
      drain();

      // reset while a B response is pending
      b_rready = 1'b0;
      xfer(1, 0, 5, '0, '0);
      chk("rb_pre_rvalid", DW'(b_rvalid), 1);
      b_req = 1'b1; b_we = 1'b0; b_addr = 4'd5;
      #2;
      rst = 1'b1;
      #1;
      chk("rb_rvalid", DW'(b_rvalid), '0);
      chk("rb_csb", DW'(sram_csb), 1);
      chk("rb_b_ready", DW'(b_ready), '0);
      qb.delete();
      tick();
      rst = 1'b0; b_req = 1'b0; b_rready = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
      @(negedge clk);
      chk("rb_idle", DW'(b_rvalid), '0);
      chk("rb_first_gnt", DW'(a_ready), 1);
      tick();
      a_req = 1'b0;
      drain();

      // back-to-back reads, one grant per cycle
      for (int i = 0; i < 4; i++) begin
         w = 32'h1111_0000 + 32'(i);
         xfer(0, 1, i, '1, {8{w}});
      end
      a_req = 1'b1; a_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_addr = AW'(i);
         @(negedge clk);
         chk("b2b_gnt", DW'(a_ready), 1);
         chk("b2b_csb", DW'(sram_csb), '0);
         tick();
      end
      a_req = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_data_array_arbiter.md
CACHE_DATA_ARRAY_ARBITER -- requirements
Module: cache_data_array_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, SRAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, SRAM set-index width in bits.
REQ-003 SHALL have parameter NUM_WMASKS, default DATA_WIDTH/8, byte write-enable count.
REQ-004 SHALL have ports:
- clk  in  1  single clock; every register is clocked on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_req, b_req  in  1  access request from port A (core) / port B (fill/writeback).
- a_we, b_we  in  1  1 = write, 0 = read.
- a_addr, b_addr  in  ADDR_WIDTH  set index.
- a_wmask, b_wmask  in  NUM_WMASKS  byte enables; ignored on reads.
- a_wdata, b_wdata  in  DATA_WIDTH  write data.
- a_ready, b_ready  out  1  grant; the request is accepted on a cycle where req and ready are both high.
- a_rvalid, b_rvalid  out  1  read data valid.
- a_rready, b_rready  in  1  read data accepted.
- a_rdata, b_rdata  out  DATA_WIDTH  read data, both driven from sram_dout.
- sram_csb, sram_web  out  1  active-low chip select / write enable to the SRAM.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wmask  out  NUM_WMASKS  SRAM byte write mask.
- sram_din  out  DATA_WIDTH  SRAM write data.
- sram_dout  in  DATA_WIDTH  SRAM read data; valid from the posedge after capture and held while sram_csb is high.

Function
REQ-005 SHALL issue at most one SRAM access per cycle, and only on a grant.
- Grant cycle: sram_csb=0, sram_web=~we; addr, wmask and wdata are taken combinationally from the granted port.
- Otherwise: sram_csb=1, other SRAM outputs don't-care.
REQ-006 A requester SHALL hold req, we, addr, wmask and wdata stable from req assertion until ready; the arbiter SHALL NOT withdraw a ready already given within that cycle.
REQ-007 Write SHALL complete on acceptance and SHALL produce no response.
REQ-008 Read accepted in cycle N SHALL assert that port's rvalid from cycle N+1 until the cycle in which rvalid and rready are both high.
REQ-009 Response state machine SHALL have states IDLE, RESP_A and RESP_B.
- Read grant → RESP_A or RESP_B for the granted port.
- Handshake with no new read grant → IDLE.
- Handshake with a new read grant in the same cycle → RESP_x for the new port.
REQ-010 Stall: in RESP_x with x_rready low, both ready outputs SHALL be 0 and sram_csb=1, so sram_dout holds.
REQ-011 In RESP_x with x_rready high, a new grant SHALL be allowed in the same cycle (back-to-back reads, 1 access/cycle).
REQ-012 A read accepted one cycle after a write to the same addr SHALL return the newly written bytes.
REQ-013 Bytes with wmask=0 SHALL be preserved; all-zero wmask on a write SHALL still grant, with no data change.
REQ-014 Only one rvalid SHALL be high at any time.

Reset
REQ-015 While rst is high, asynchronously:
- state=IDLE, a_ready=b_ready=0, a_rvalid=b_rvalid=0, sram_csb=1, sram_web=1.
- last-grant register = B.
REQ-016 Reset mid-operation SHALL discard any pending response with no SRAM access.
REQ-017 First cycle after reset deassertion SHALL arbitrate normally.

Configuration
REQ-018 With CACHE_ARB_RR_EN defined:
- Arbitration is round-robin; when both ports request, the port not in the last-grant register wins.
- The last-grant register updates on every grant.
REQ-019 Without CACHE_ARB_RR_EN:
- Fixed priority; A always wins contention.
- Last-grant register is absent or unused.

Verification
REQ-020 Bench SHALL cover:
- A write addr 3, wmask all-ones, data 0xAA..AA; next cycle A read addr 3 → a_rvalid next cycle, a_rdata=0xAA..AA.
- B write addr 5 with wmask=0x0000_0001, data 0x..FF over prior 0x00..00 → read returns 0x00..00FF.
- A read addr 1 with a_rready=0 for 3 cycles, b_req high → b_ready=0 and sram_csb=1 during stall; rdata stable; B granted in the handshake cycle.
- A and B both requesting for 4 cycles → with CACHE_ARB_RR_EN grants alternate A,B,A,B; without it grants A,A,A,A.
- rst pulsed while in RESP_B → b_rvalid=0 immediately, sram_csb=1, state IDLE.
- Back-to-back reads addr 0..3 with rready tied high → one grant per cycle, rdata in order.
